button_conditioner: RTL and testbench

- Conditions one raw pushbutton (btn[0] on the board) into clean, single-cycle event pulses for the bikelight mode FSM, which sits directly downstream.
- Performs a 2-FF synchronisation and a counter-based debounce, then derives press, release, short-press and long-press events.
- The bikelight consumes `press` (or `short_press`) as its mode-toggle input in place of the raw button level.

---
 rtl/button_conditioner_pkg.sv | 26 ++
 rtl/button_conditioner_if.sv | 28 ++
 rtl/button_conditioner_sync_debounce.sv | 51 +++++
 rtl/button_conditioner.sv | 78 +++++++
 tb/tb_button_conditioner.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner.
// Holds the clock rate, the default debounce and long-press lengths, the short
// lengths used in simulation, the event bundle type and a counter-width helper.
package button_conditioner_pkg;

   localparam int CLK_HZ                  = 125_000_000;
   localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
   localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;        // 1 s
   localparam int TB_DEBOUNCE             = 4;
   localparam int TB_LONG                 = 16;

   // One-cycle event pulses produced for the downstream mode FSM.
   typedef struct packed {
      logic press;
      logic btn_release;
      logic short_press;
      logic long_press;
   } btn_evt_t;

   // Width of a counter that must hold 0..n-1.
   // The result is never below 1 bit, so small parameter values still give a legal vector.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button signal bundle between the board pin and the bikelight mode FSM.
//   btn_raw     : raw, asynchronous, bouncy button level
//   btn_level   : debounced button level
//   press       : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0 ("release" is a reserved word)
//   short_press : pulse with btn_release when the hold ended before long_press
//   long_press  : pulse once per hold, LONG_CYCLES after press
// master = the conditioner, slave = the consumer/driver side.
interface button_conditioner_if;

   logic btn_raw;
   logic btn_level;
   logic press;
   logic btn_release;
   logic short_press;
   logic long_press;

   modport master (
      input  btn_raw,
      output btn_level, press, btn_release, short_press, long_press
   );

   modport slave (
      output btn_raw,
      input  btn_level, press, btn_release, short_press, long_press
   );

endinterface

// File: rtl/button_conditioner_sync_debounce.sv
// Two-flop synchroniser followed by a counter debounce.
//   clk, reset : system clock, synchronous active-high reset
//   btn_raw    : asynchronous button level
//   btn_level  : debounced, registered level
//   btn_toggle : high in the cycle before btn_level flips. It lets the parent
//                register edge pulses that coincide with the new level.
module sync_debounce
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_toggle
);

   localparam int DEB_W = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic [DEB_W-1:0] deb_cnt;

   // The flip happens on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
   assign btn_toggle = (s2 != btn_level) && (deb_cnt == DEB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         deb_cnt   <= '0;
         btn_level <= 1'b0;
      end else begin
         // synchroniser stage
         s1 <= btn_raw;
         s2 <= s1;
         // debounce stage: any agreeing sample restarts the count
         if (s2 == btn_level) begin
            deb_cnt <= '0;
         end else if (btn_toggle) begin
            btn_level <= s2;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner for the bikelight mode FSM.
// It synchronises and debounces the raw button (sync_debounce), then derives
// registered one-cycle events: press, release, short press and long press.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : button_conditioner_if.master (btn_raw in, level/events out)
// long_press fires LONG_CYCLES cycles after the press cycle, at most once per hold.
// A release on that same edge takes priority and reports a short press.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   button_conditioner_if.master   bus
);

   localparam int HOLD_W = cnt_w(LONG_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_CYCLES);

   logic              btn_level;
   logic              btn_toggle;
   logic              rising;
   logic              falling;
   logic [HOLD_W-1:0] hold_cnt;
   logic              long_done;
   btn_evt_t          evt;

   sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sync_debounce (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (bus.btn_raw),
      .btn_level  (btn_level),
      .btn_toggle (btn_toggle)
   );

   assign rising  = btn_toggle & ~btn_level;
   assign falling = btn_toggle &  btn_level;

   // hold_cnt is 1 in the press cycle.
   // It reaches LONG_CYCLES one cycle before long_press and then freezes.
   always_ff @(posedge clk) begin
      if (reset) begin
         evt       <= '0;
         hold_cnt  <= '0;
         long_done <= 1'b0;
      end else begin
         evt.press       <= rising;
         evt.btn_release <= falling;
         evt.short_press <= falling & ~long_done;
         evt.long_press  <= 1'b0;
         if (rising) begin
            hold_cnt  <= HOLD_W'(1);
            long_done <= 1'b0;
         end else if (falling) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
         end else if (btn_level && !long_done) begin
            if (hold_cnt == HOLD_LONG) begin
               evt.long_press <= 1'b1;
               long_done      <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.btn_level   = btn_level;
   assign bus.press       = evt.press;
   assign bus.btn_release = evt.btn_release;
   assign bus.short_press = evt.short_press;
   assign bus.long_press  = evt.long_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
// The output vector is {btn_level, press, btn_release, short_press, long_press}.
module tb_button_conditioner;
   import button_conditioner_pkg::*;

   localparam int D = TB_DEBOUNCE;
   localparam int L = TB_LONG;
   localparam int B_LVL = 4, B_PRESS = 3, B_REL = 2, B_SHORT = 1, B_LONG = 0;

   logic clk = 1'b0;
   logic reset;

   button_conditioner_if bif();

   button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int long_seen = 0;
   int last_long_cyc = -1;

   // Reference model.
   // The level flips once the last D synchronised samples, all taken since the
   // previous flip or reset, disagree with the level.
   // Events are derived from edge timestamps.
   int   hist[$];
   bit   m_s1, m_s2, m_level, m_long_fired;
   int   m_edge = 0;
   int   m_press_edge = -100000;
   logic [4:0] m_exp;

   task automatic model_step(input bit rst_i, input bit raw_i);
      bit lvl_old, flip, e_press, e_rel, e_short, e_long;
      if (rst_i) begin
         m_s1 = 0; m_s2 = 0; m_level = 0; m_long_fired = 0;
         hist.delete();
         m_exp = '0;
      end else begin
         lvl_old = m_level;
         hist.push_back(int'(m_s2));
         if (hist.size() > D) void'(hist.pop_front());
         flip = 0;
         if (int'(hist.size()) == D) begin
            flip = 1;
            foreach (hist[k]) if (hist[k] == int'(lvl_old)) flip = 0;
         end
         if (flip) begin
            m_level = !lvl_old;
            hist.delete();
         end
         m_s2 = m_s1;
         m_s1 = raw_i;
         e_press = flip && !lvl_old;
         e_rel   = flip && lvl_old;
         e_short = e_rel && !m_long_fired;
         e_long  = !flip && lvl_old && !m_long_fired && (m_edge == m_press_edge + L);
         if (e_press) begin m_press_edge = m_edge; m_long_fired = 0; end
         if (e_long) m_long_fired = 1;
         if (e_rel) m_long_fired = 0;
         m_exp = {m_level, e_press, e_rel, e_short, e_long};
      end
      m_edge++;
   endtask

   function automatic logic [4:0] dut_out();
      return {bif.btn_level, bif.press, bif.btn_release, bif.short_press, bif.long_press};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      bit r, b;
      logic [4:0] o;
      @(posedge clk);
      r = reset;
      b = bif.btn_raw;
      model_step(r, b);
      cyc++;
      #1;
      o = dut_out();
      if (o[B_LONG] === 1'b1) begin long_seen++; last_long_cyc = cyc; end
      check("model", o, m_exp);
   endtask

   task automatic tick_until(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wait_evt(input int sel, input int max_cyc, output int at, output bit ok);
      logic [4:0] o;
      ok = 0;
      at = -1;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         tick();
         o = dut_out();
         if (o[sel] === 1'b1) begin ok = 1; at = cyc; end
      end
   endtask

   typedef struct {
      bit         rst;
      bit         raw;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit b, input logic [4:0] e, input int n);
      vec_t v;
      v.rst = r; v.raw = b; v.exp = e;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   initial begin
      int p, p2, c0, r_at, l_at, base, run;
      bit ok;
      logic [4:0] o;

      reset = 1'b1;
      bif.btn_raw = 1'b0;

      // press after reset, then a short release
      add(1, 0, 5'b00000, 2);
      add(0, 1, 5'b00000, 5);
      add(0, 1, 5'b11000, 1);
      add(0, 1, 5'b10000, 2);
      add(0, 0, 5'b10000, 5);
      add(0, 0, 5'b00110, 1);
      add(0, 0, 5'b00000, 2);
      // bounce: nothing may pass
      add(1, 0, 5'b00000, 1);
      for (int i = 0; i < 3; i++) begin
         add(0, 1, 5'b00000, 1);
         add(0, 0, 5'b00000, 1);
      end
      add(0, 0, 5'b00000, 4);
      add(0, 1, 5'b00000, 3);
      add(0, 0, 5'b00000, 6);

      foreach (tbl[i]) begin
         reset = tbl[i].rst;
         bif.btn_raw = tbl[i].raw;
         tick();
         check("table", dut_out(), tbl[i].exp);
      end

      // short hold
      bif.btn_raw = 1'b1;
      wait_evt(B_PRESS, 20, p, ok);
      check("short_press_seen", ok, 1);
      base = long_seen;
      tick_until(p + 4);
      bif.btn_raw = 1'b0;
      c0 = cyc + 1;
      wait_evt(B_REL, 20, r_at, ok);
      check("short_rel_seen", ok, 1);
      check("short_rel_latency", r_at - c0, D + 1);
      o = dut_out();
      check("short_flag", o[B_SHORT], 1);
      tick_until(cyc + 20);
      check("short_no_long", long_seen - base, 0);

      // long hold
      bif.btn_raw = 1'b1;
      wait_evt(B_PRESS, 20, p, ok);
      check("long_press_seen", ok, 1);
      base = long_seen;
      tick_until(p + 60);
      check("long_count", long_seen - base, 1);
      check("long_timing", last_long_cyc - p, L);
      bif.btn_raw = 1'b0;
      wait_evt(B_REL, 20, r_at, ok);
      check("long_rel_seen", ok, 1);
      o = dut_out();
      check("long_rel_short", o[B_SHORT], 0);
      tick_until(cyc + 10);

      // reset mid-hold
      bif.btn_raw = 1'b1;
      wait_evt(B_PRESS, 20, p, ok);
      check("rst_press_seen", ok, 1);
      tick_until(p + 7);
      reset = 1'b1;
      tick();
      check("rst_outputs", dut_out(), 5'b00000);
      reset = 1'b0;
      c0 = cyc + 1;
      wait_evt(B_PRESS, 20, p2, ok);
      check("rst_repress_seen", ok, 1);
      check("rst_repress_latency", p2 - c0, D + 1);
      wait_evt(B_LONG, 30, l_at, ok);
      check("rst_long_seen", ok, 1);
      check("rst_long_timing", l_at - p2, L);
      bif.btn_raw = 1'b0;
      wait_evt(B_REL, 20, r_at, ok);
      check("rst_rel_seen", ok, 1);
      tick_until(cyc + 10);

      // release lands on the long_press edge
      bif.btn_raw = 1'b1;
      wait_evt(B_PRESS, 20, p, ok);
      check("race_press_seen", ok, 1);
      base = long_seen;
      tick_until(p + L - D - 2);
      bif.btn_raw = 1'b0;
      wait_evt(B_REL, 30, r_at, ok);
      check("race_rel_seen", ok, 1);
      check("race_rel_timing", r_at - p, L);
      o = dut_out();
      check("race_vector", o, 5'b00110);
      tick_until(cyc + 20);
      check("race_no_long", long_seen - base, 0);

      // randomized runs against the model
      run = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run == 0) begin
            bif.btn_raw = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 40);
         end
         run--;
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
